// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit character-LCD controller.
// Holds the state enum, the power-up init ROM and the long-execution opcode list.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrWait,
    StInit,
    StIdle,
    StSetup,
    StEnHi,
    StHold,
    StWait,
    StSend
  } state_e;

  // Four 8-bit-mode wake-up nibbles, then function set / display on / entry mode / clear.
  localparam logic [3:0] InitNibbles [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
  localparam logic [7:0] InitBytes   [4] = '{8'h28, 8'h0C, 8'h06, 8'h01};
  localparam logic [3:0] InitLast        = 4'd11;

  localparam logic [7:0] CmdClear   = 8'h01;
  localparam logic [7:0] CmdHome    = 8'h02;
  localparam logic [7:0] CmdHomeAlt = 8'h03;

  function automatic logic is_long_cmd(logic rs, logic [7:0] data);
    return !rs && (data == CmdClear || data == CmdHome || data == CmdHomeAlt);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Single-nibble strobe engine: SETUP -> EN_HI -> HOLD -> optional WAIT.
// done is high in the last cycle of a nibble so a follow-on start chains with no gap.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned EN_CYC = 3,
  parameter int unsigned CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    nibble,
  input  logic          rs,
  input  logic [CW-1:0] wait_cyc,
  output logic          done,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic [3:0]    lcd_d
);

  state_e        st_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] wait_q;

  assign done = ((st_q == StHold) && (wait_q == '0)) || ((st_q == StWait) && (cnt_q == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= StIdle;
      cnt_q  <= '0;
      wait_q <= '0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_d  <= '0;
    end else begin
      case (st_q)
        StSetup: begin
          st_q  <= StEnHi;
          lcd_e <= 1'b1;
          cnt_q <= CW'(EN_CYC - 1);
        end
        StEnHi: begin
          if (cnt_q == '0) begin
            st_q  <= StHold;
            lcd_e <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StHold: begin
          if (wait_q != '0) begin
            st_q  <= StWait;
            cnt_q <= wait_q - CW'(1);
          end
        end
        StWait: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
      if (done) st_q <= StIdle;
      // lcd_d/lcd_rs only change on a new start, so they hold through idle.
      if (start && (st_q == StIdle || done)) begin
        st_q   <= StSetup;
        lcd_d  <= nibble;
        lcd_rs <= rs;
        wait_q <= wait_cyc;
      end
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 controller top: power-up wait, init ROM sequencing and host byte handshake.
// Define LCD_CTRL_STATUS_LED_EN to add an active-low status LED port.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = 75000,
  parameter int unsigned EN_CYC      = 3,
  parameter int unsigned EXEC_CYC    = 250,
  parameter int unsigned LONG_CYC    = 20500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d
`ifdef LCD_CTRL_STATUS_LED_EN
  ,
  output logic [7:0] led
`endif
);

  localparam int unsigned CW =
      $clog2(max_u(max_u(POWERUP_CYC, EN_CYC), max_u(EXEC_CYC, LONG_CYC)) + 1);

  state_e        state_q;
  logic [CW-1:0] pwr_cnt_q;
  logic [3:0]    idx_q;
  logic [7:0]    byte_q;
  logic          rs_q;
  logic          lo_q;
  logic          wr_ready_q;
  logic          init_done_q;

  logic          tx_done;
  logic          start;
  logic [3:0]    nib;
  logic          nib_rs;
  logic [CW-1:0] nib_wait;
  logic [3:0]    init_idx_nxt;
  logic [7:0]    init_byte;

  // Start is combinational so the first SETUP lands on the accepting edge itself.
  always_comb begin
    start        = 1'b0;
    nib          = wr_data[7:4];
    nib_rs       = wr_rs;
    nib_wait     = '0;
    init_idx_nxt = (state_q == StInit) ? idx_q + 4'd1 : 4'd0;
    init_byte    = InitBytes[2'((init_idx_nxt - 4'd4) >> 1)];
    case (state_q)
      StPwrWait: start = (pwr_cnt_q == CW'(POWERUP_CYC));
      StInit:    start = tx_done && (idx_q != InitLast);
      StIdle:    start = wr_valid && wr_ready_q;
      StSend:    start = tx_done && !lo_q;
      default:   ;
    endcase
    if (state_q == StPwrWait || state_q == StInit) begin
      nib_rs = 1'b0;
      if (init_idx_nxt < 4'd4) begin
        nib      = InitNibbles[init_idx_nxt[1:0]];
        nib_wait = CW'(LONG_CYC);
      end else if (!init_idx_nxt[0]) begin
        nib = init_byte[7:4];
      end else begin
        nib      = init_byte[3:0];
        nib_wait = is_long_cmd(1'b0, init_byte) ? CW'(LONG_CYC) : CW'(EXEC_CYC);
      end
    end else if (state_q == StSend) begin
      nib      = byte_q[3:0];
      nib_rs   = rs_q;
      nib_wait = is_long_cmd(rs_q, byte_q) ? CW'(LONG_CYC) : CW'(EXEC_CYC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPwrWait;
      pwr_cnt_q   <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      lo_q        <= 1'b0;
      wr_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        StPwrWait: begin
          if (start) begin
            state_q <= StInit;
            idx_q   <= '0;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + CW'(1);
          end
        end
        StInit: begin
          if (tx_done) begin
            if (idx_q == InitLast) begin
              state_q     <= StIdle;
              wr_ready_q  <= 1'b1;
              init_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        StIdle: begin
          if (start) begin
            state_q    <= StSend;
            byte_q     <= wr_data;
            rs_q       <= wr_rs;
            lo_q       <= 1'b0;
            wr_ready_q <= 1'b0;
          end
        end
        StSend: begin
          if (tx_done) begin
            if (lo_q) begin
              state_q    <= StIdle;
              wr_ready_q <= 1'b1;
            end else begin
              lo_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  lcd_nibble_tx #(
    .EN_CYC (EN_CYC),
    .CW     (CW)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .nibble   (nib),
    .rs       (nib_rs),
    .wait_cyc (nib_wait),
    .done     (tx_done),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_d    (lcd_d)
  );

  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;
  assign lcd_rw    = 1'b0;

`ifdef LCD_CTRL_STATUS_LED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 8'hFF;
    end else begin
      led <= {5'b11111, ~lcd_e, (state_q == StIdle), ~init_done_q};
    end
  end
`endif

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: cycle-timeline reference model plus literal pins.
// Model schedules nibbles/ready windows from the timing rules and is compared every cycle.
module tb_lcd_ctrl;

  localparam int PWR  = 20;
  localparam int EN   = 2;
  localparam int EXEC = 5;
  localparam int LONG = 10;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_d;
`ifdef LCD_CTRL_STATUS_LED_EN
  logic [7:0] led;
`endif

  lcd_ctrl #(
    .POWERUP_CYC (PWR),
    .EN_CYC      (EN),
    .EXEC_CYC    (EXEC),
    .LONG_CYC    (LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_d     (lcd_d)
`ifdef LCD_CTRL_STATUS_LED_EN
    ,
    .led       (led)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference timeline: expected outputs per cycle after reset release.
  bit         e_m   [MAXC];
  logic [3:0] d_m   [MAXC];
  bit         rs_m  [MAXC];
  bit         rdy_m [MAXC];
  int         cyc;
  int         init_end;

  logic [3:0] nib_q [$];
  bit         nrs_q [$];
  int         hl_q  [$];
  int         first_rise;
  int         done_cyc;
  int         dut_acc;
  bit         prev_e;
  int         hi_len;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int post_wait(input bit rs, input logic [7:0] b);
    return (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? LONG : EXEC;
  endfunction

  task automatic put_nib(input int s, input logic [3:0] d, input bit rs);
    for (int c = s; c < MAXC; c++) begin
      d_m[c]  = d;
      rs_m[c] = rs;
    end
    for (int c = s + 1; c <= s + EN && c < MAXC; c++) e_m[c] = 1'b1;
  endtask

  task automatic put_byte(input int s, input bit rs, input logic [7:0] b, output int nxt);
    put_nib(s, b[7:4], rs);
    put_nib(s + 2 + EN, b[3:0], rs);
    nxt = s + 4 + 2 * EN + post_wait(rs, b);
  endtask

  task automatic model_reset();
    logic [3:0] inib [4];
    logic [7:0] ibyte [4];
    int s;
    int n;
    inib  = '{4'h3, 4'h3, 4'h3, 4'h2};
    ibyte = '{8'h28, 8'h0C, 8'h06, 8'h01};
    for (int c = 0; c < MAXC; c++) begin
      e_m[c] = 1'b0; d_m[c] = 4'h0; rs_m[c] = 1'b0; rdy_m[c] = 1'b0;
    end
    cyc = 0;
    s = PWR + 1;
    for (int i = 0; i < 4; i++) begin
      put_nib(s, inib[i], 1'b0);
      s += 2 + EN + LONG;
    end
    for (int i = 0; i < 4; i++) begin
      put_byte(s, 1'b0, ibyte[i], n);
      s = n;
    end
    init_end = s;
    for (int c = s; c < MAXC; c++) rdy_m[c] = 1'b1;
  endtask

  always @(posedge clk) begin : model
    int nxt;
    if (!rst && cyc < MAXC - 1) begin
      cyc++;
      if (wr_valid && rdy_m[cyc-1]) begin
        put_byte(cyc, wr_rs, wr_data, nxt);
        for (int c = cyc; c < nxt && c < MAXC; c++) rdy_m[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [8:0] got;
    logic [8:0] exp;
    if (rst) begin
      prev_e = 1'b0;
      hi_len = 0;
    end else if (cyc < MAXC) begin
      exp = {e_m[cyc], d_m[cyc], rs_m[cyc], 1'b0, rdy_m[cyc], (cyc >= init_end)};
      got = {lcd_e, lcd_d, lcd_rs, lcd_rw, wr_ready, init_done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle %0d {e,d,rs,rw,ready,done}: got %b, expected %b", cyc, got, exp);
      end
      if (lcd_e) hi_len++;
      if (prev_e && !lcd_e) begin
        nib_q.push_back(lcd_d);
        nrs_q.push_back(lcd_rs);
        hl_q.push_back(hi_len);
        hi_len = 0;
      end
      if (lcd_e && first_rise < 0) first_rise = cyc;
      if (init_done && done_cyc < 0) done_cyc = cyc;
      if (wr_valid && wr_ready) dut_acc++;
      prev_e = lcd_e;
    end
  end

  task automatic clear_caps();
    nib_q.delete();
    nrs_q.delete();
    hl_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    clear_caps();
    first_rise = -1;
    done_cyc   = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({lcd_e, lcd_d, lcd_rs, lcd_rw, wr_ready, init_done}), 0);
`ifdef LCD_CTRL_STATUS_LED_EN
    chk("led in reset", int'(led), 8'hFF);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = -1;
    for (int i = 0; i < 300 && c < 0; i++) begin
      @(negedge clk);
      if (wr_ready) c = cyc;
    end
    if (c < 0) chk("wr_ready timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Present a byte and return at posedge+1 of the accepting edge.
  task automatic send(input bit rs, input logic [7:0] d, input bit keep, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    wr_rs = rs;
    wr_data = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (wr_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept timeout", 0, 1);
    else acc = cyc;
    if (!keep) begin
      wr_valid = 1'b0;
      wr_data  = 8'($urandom);
      wr_rs    = 1'($urandom);
    end
  endtask

  task automatic check_init();
    logic [3:0] exp_init [12];
    int c;
    int ones;
    exp_init = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    c = -1;
    for (int i = 0; i < 400 && c < 0; i++) begin
      @(negedge clk);
      if (init_done) c = cyc;
    end
    if (c < 0) chk("init_done timeout", 0, 1);
    @(posedge clk);
    #1;
    chk("init nibble count", nib_q.size(), 12);
    for (int i = 0; i < 12 && i < nib_q.size(); i++)
      chk($sformatf("init nibble %0d", i), int'(nib_q[i]), int'(exp_init[i]));
    ones = 0;
    foreach (nrs_q[i]) ones += int'(nrs_q[i]);
    chk("init rs high count", ones, 0);
    chk("first e rise cycle", first_rise, 22);
    chk("init_done rise cycle", done_cyc, 134);
`ifdef LCD_CTRL_STATUS_LED_EN
    chk("led0 after init", int'(led[0]), 0);
`endif
  endtask

  task automatic byte_test(input string name, input bit rs, input logic [7:0] d,
                           input int exp_lat);
    int acc;
    int r;
    clear_caps();
    send(rs, d, 1'b0, acc);
`ifdef LCD_CTRL_STATUS_LED_EN
    @(posedge clk);
    @(negedge clk);
    chk({name, " led1 busy"}, int'(led[1]), 0);
`endif
    wait_ready(r);
    chk({name, " ready latency"}, r - acc, exp_lat);
    chk({name, " nibble count"}, nib_q.size(), 2);
    if (nib_q.size() == 2) begin
      chk({name, " high nibble"}, int'(nib_q[0]), int'(d[7:4]));
      chk({name, " low nibble"}, int'(nib_q[1]), int'(d[3:0]));
      chk({name, " rs"}, int'({nrs_q[0], nrs_q[1]}), rs ? 3 : 0);
      chk({name, " e width"}, hl_q[0] * 100 + hl_q[1], 202);
    end
  endtask

  initial begin
    int a1;
    int a2;
    int r;
    int acc0;
    bit keep;
    logic [7:0] d;

    do_reset();
    check_init();

    byte_test("data 0x41", 1'b1, 8'h41, 13);
    byte_test("cmd 0x01", 1'b0, 8'h01, 18);
    byte_test("cmd 0x80", 1'b0, 8'h80, 13);
    byte_test("cmd 0x02", 1'b0, 8'h02, 18);

    // wr_valid held across the busy period with two queued bytes.
    acc0 = dut_acc;
    send(1'b1, 8'h48, 1'b1, a1);
    send(1'b1, 8'h49, 1'b0, a2);
    wait_ready(r);
    chk("b2b accept spacing", a2 - a1, 14);
    chk("b2b accept count", dut_acc - acc0, 2);

    for (int i = 0; i < 30; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      keep = 1'($urandom_range(0, 1));
      send(1'($urandom), d, keep, a1);
      if (!keep) repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    wr_valid = 1'b0;
    wait_ready(r);

    // Reset while lcd_e is high for a data byte.
    send(1'b1, 8'h55, 1'b0, a1);
    @(posedge clk);
    #1;
    chk("e high before reset", int'(lcd_e), 1);
    rst = 1'b1;
    #1;
    chk("async reset e/ready/done", int'({lcd_e, wr_ready, init_done}), 0);
    do_reset();
    check_init();
    byte_test("post-reset 0x41", 1'b1, 8'h41, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

HD44780-compatible character-LCD controller for the ispMACH 4256ZE breakout board. Runs the mandatory power-up/4-bit initialisation sequence autonomously after reset, then accepts command and data bytes from the host logic over a valid/ready handshake. Each byte goes out as two nibbles with correct E-strobe, setup, hold and execution timing. Sits between the board application logic and the LCD header pins; write-only (R/W tied low), no busy-flag polling.

## Interface
- POWERUP_CYC, 75000: cycles to wait after reset before the first nibble (15 ms @ 5 MHz).
- EN_CYC, 3: cycles lcd_e is held high per nibble (≥450 ns).
- EXEC_CYC, 250: post-byte wait for normal commands/data (50 µs).
- LONG_CYC, 20500: wait after init nibbles and after clear/home commands (4.1 ms).
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  host has a byte to send.
- wr_ready  output  1  controller can accept a byte this cycle.
- wr_rs  input  1  0 = command, 1 = data; sampled on accept.
- wr_data  input  8  byte; sampled on accept.
- init_done  output  1  high once the init sequence completes; stays high until reset.
- lcd_rs  output  1  LCD register select.
- lcd_rw  output  1  constant 0.
- lcd_e  output  1  LCD enable strobe.
- lcd_d  output  4  LCD D7..D4.

## Operation
- Reset (async): state PWR_WAIT; lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, wr_ready=0, init_done=0, counters cleared. Reset mid-transfer aborts immediately (lcd_e low the same instant); full re-init follows release.
- PWR_WAIT: count POWERUP_CYC cycles, then INIT.
- INIT: nibbles 0x3, 0x3, 0x3, 0x2 (rs=0), each followed by LONG_CYC wait; then bytes 0x28, 0x0C, 0x06, 0x01 (rs=0) as nibble pairs, 0x01 followed by LONG_CYC, others by EXEC_CYC. Then init_done=1, state IDLE.
- IDLE: wr_ready=1. Transfer occurs on a rising edge with wr_valid&wr_ready; wr_rs/wr_data captured; wr_ready=0 from the next cycle.
- Nibble engine states per nibble: SETUP (1 cycle, lcd_d/lcd_rs driven, e=0) → EN_HI (EN_CYC cycles, e=1) → HOLD (1 cycle, e=0, lcd_d/lcd_rs unchanged) → WAIT (N cycles, N=0 between high and low nibble).
- Byte order: high nibble then low nibble. Post-byte wait = LONG_CYC if rs=0 and data ∈ {0x01, 0x02, 0x03}, else EXEC_CYC.
- lcd_d/lcd_rs hold last value while idle; no glitches on lcd_e.
- Counters are down-counters sized $clog2 of the largest parameter; a wait of N lasts exactly N cycles; N=0 skips WAIT.

## Timing
- Host byte: wr_ready reasserts exactly 4 + 2·EN_CYC + wait cycles after the accepting edge.
- First lcd_e rise: POWERUP_CYC + 2 cycles after reset release.
- lcd_d stable ≥1 cycle before lcd_e rises and ≥1 cycle after it falls.
- wr_valid held across busy period: no acceptance until wr_ready high; no combinational path wr_valid → wr_ready.

## Configuration
- LCD_CTRL_STATUS_LED_EN defined: adds output led[7:0], active-low (0 = LED on): led[0]=~init_done, led[1]=~(state≠IDLE), led[2]=~lcd_e, led[7:3]=5'b11111; registered, reset value 8'hFF.
- Undefined: no led port, no related logic.

## Structure
- Package lcd_pkg: state enum (PWR_WAIT, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT), init nibble/byte constant arrays, long-command opcode constants.
- Sub-module lcd_nibble_tx: SETUP/EN_HI/HOLD/WAIT engine with start, nibble, rs, wait_cyc inputs and done pulse; lcd_ctrl holds sequencing, init ROM index and handshake.

## Test plan
Benches use POWERUP_CYC=20, EN_CYC=2, EXEC_CYC=5, LONG_CYC=10.
- Reset release → lcd_d sampled at each lcd_e fall reads 3,3,3,2,2,8,0,C,0,6,0,1; lcd_rs=0 throughout; init_done rises after final 10-cycle wait; first e rise at cycle 22.
- Write rs=1, data 0x41 → nibbles 4 then 1 with lcd_rs=1, e high 2 cycles each; wr_ready back high exactly 13 cycles after accept.
- Write rs=0, data 0x01 → same nibble shape, wr_ready back after 4+4+10=18 cycles; data 0x80 → 13 cycles.
- wr_valid held high with 0x48 then 0x49 → exactly two accepts, no overlap of e pulses, second accept on first cycle wr_ready high.
- rst asserted during EN_HI of a data byte → lcd_e, wr_ready, init_done low immediately; after release full init sequence repeats.
- LCD_CTRL_STATUS_LED_EN defined → led=8'hFF in reset, led[0]=0 after init_done, led[1] low while a byte is in flight.
